// File: rtl/sm_mcu_cpu_ocimem_monitor.sv
// ============================================================================
// sm_mcu_cpu_ocimem_monitor : JTAG-driven word read/write monitor for OCI RAM
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sm_mcu_cpu_ocimem_monitor #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  output logic [AW-1:0] ociram_addr,
  output logic          ociram_rd,
  output logic          ociram_wr,
  output logic [31:0]   ociram_wrdata,
  input  logic [31:0]   ociram_rddata,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAP   = 2'd2,
    WR_DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] mon_areg, mon_areg_nxt;
  logic [AW-1:0] addr_nxt;
  logic [AW-1:0] addr_inc;
  logic          rd_nxt, wr_nxt, err_nxt;
  logic [31:0]   wrdata_nxt, dreg_nxt;
  logic          any_cmd;
  logic          unused_jdo;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({{(32-AW){1'b0}}, a} < DEPTH_U);
  endfunction

  assign any_cmd       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign addr_inc      = mon_areg + AW'(1);
  assign monitor_ready = (state == IDLE);
  assign unused_jdo    = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_nxt    = state;
    mon_areg_nxt = mon_areg;
    addr_nxt     = ociram_addr;
    wrdata_nxt   = ociram_wrdata;
    dreg_nxt     = MonDReg;
    err_nxt      = monitor_error;
    rd_nxt       = 1'b0;
    wr_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (take_action_ocimem_a) begin
          mon_areg_nxt = jdo[AW-1:0];
          // Clear first so an out-of-range read in this same command re-raises it.
          if (jdo[35]) err_nxt = 1'b0;
          if (jdo[34]) begin
            if (in_range(jdo[AW-1:0])) begin
              rd_nxt    = 1'b1;
              addr_nxt  = jdo[AW-1:0];
              state_nxt = RD_ISSUE;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = WR_DONE;
            end
          end
        end else if (take_action_ocimem_b) begin
          dreg_nxt     = jdo[34:3];
          mon_areg_nxt = addr_inc;
          state_nxt    = WR_DONE;
          if (in_range(mon_areg)) begin
            wr_nxt     = 1'b1;
            addr_nxt   = mon_areg;
            wrdata_nxt = jdo[34:3];
          end else begin
            err_nxt = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          mon_areg_nxt = addr_inc;
          if (in_range(addr_inc)) begin
            rd_nxt    = 1'b1;
            addr_nxt  = addr_inc;
            state_nxt = RD_ISSUE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WR_DONE;
          end
        end
      end
      RD_ISSUE: begin
        state_nxt = RD_CAP;
        if (any_cmd) err_nxt = 1'b1;
      end
      RD_CAP: begin
        dreg_nxt  = ociram_rddata;
        state_nxt = IDLE;
        if (any_cmd) err_nxt = 1'b1;
      end
      WR_DONE: begin
        state_nxt = IDLE;
        if (any_cmd) err_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mon_areg      <= '0;
      ociram_addr   <= '0;
      ociram_rd     <= 1'b0;
      ociram_wr     <= 1'b0;
      ociram_wrdata <= '0;
      MonDReg       <= '0;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      mon_areg      <= mon_areg_nxt;
      ociram_addr   <= addr_nxt;
      ociram_rd     <= rd_nxt;
      ociram_wr     <= wr_nxt;
      ociram_wrdata <= wrdata_nxt;
      MonDReg       <= dreg_nxt;
      monitor_error <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm_mcu_cpu_ocimem_monitor.sv
// Scoreboard bench for sm_mcu_cpu_ocimem_monitor: directed cases then random command traffic.
`timescale 1ns/1ps
`default_nettype none

module tb_sm_mcu_cpu_ocimem_monitor;

  localparam int AW    = 8;
  localparam int DEPTH = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          ta_a = 1'b0, ta_b = 1'b0, tna = 1'b0;
  logic [AW-1:0] ociram_addr;
  logic          ociram_rd, ociram_wr;
  logic [31:0]   ociram_wrdata;
  logic [31:0]   ociram_rddata = '0;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;

  sm_mcu_cpu_ocimem_monitor #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna),
    .ociram_addr             (ociram_addr),
    .ociram_rd               (ociram_rd),
    .ociram_wr               (ociram_wr),
    .ociram_wrdata           (ociram_wrdata),
    .ociram_rddata           (ociram_rddata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM seen by the DUT; read data is registered one cycle after the strobe.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (ociram_wr) ram[ociram_addr] <= ociram_wrdata;
    if (ociram_rd) ociram_rddata <= ram[ociram_addr];
  end

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          due;
  } strobe_t;

  typedef struct {
    logic [31:0] dreg;
    int          due;
  } done_t;

  strobe_t     sq[$];
  done_t       dq[$];
  logic [31:0] mem_model [256];
  logic [7:0]  m_addr = '0;
  logic [31:0] m_dreg = '0;
  logic        m_err = 1'b0;
  int          ready_at = 0;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [37:0] mk_a(input logic clr, input logic rd, input logic [7:0] a);
    return {2'b00, clr, rd, 26'h0, a};
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  // Reference model: applied once the command has been sampled at edge e.
  task automatic model_read(input int e);
    if (int'(m_addr) < DEPTH) begin
      sq.push_back('{1'b0, m_addr, 32'h0, e});
      m_dreg = mem_model[m_addr];
      dq.push_back('{m_dreg, e + 2});
      ready_at = e + 3;
    end else begin
      m_err = 1'b1;
      dq.push_back('{m_dreg, e + 1});
      ready_at = e + 2;
    end
  endtask

  task automatic model_apply(input int e, input logic a, input logic b, input logic n,
                             input logic [37:0] j);
    logic [31:0] d;
    if (!(a | b | n)) return;
    if (e < ready_at) begin
      m_err = 1'b1;
      return;
    end
    if (a) begin
      m_addr = j[7:0];
      if (j[35]) m_err = 1'b0;
      if (j[34]) model_read(e);
    end else if (b) begin
      d = j[34:3];
      m_dreg = d;
      if (int'(m_addr) < DEPTH) begin
        sq.push_back('{1'b1, m_addr, d, e});
        mem_model[m_addr] = d;
      end else begin
        m_err = 1'b1;
      end
      dq.push_back('{d, e + 1});
      ready_at = e + 2;
      m_addr = m_addr + 8'd1;
    end else begin
      m_addr = m_addr + 8'd1;
      model_read(e);
    end
  endtask

  // Called #1 after a rising edge; the pulse is sampled at the next edge.
  task automatic issue(input logic a, input logic b, input logic n, input logic [37:0] j);
    ta_a = a; ta_b = b; tna = n; jdo = j;
    @(posedge clk); #1;
    ta_a = 1'b0; ta_b = 1'b0; tna = 1'b0;
    model_apply(cyc, a, b, n, j);
  endtask

  task automatic idle(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // Monitor: every strobe and every return of ready is matched against the scoreboard.
  logic prev_ready = 1'b1;
  always @(negedge clk) begin : mon
    strobe_t s;
    done_t   d;
    if (!reset) begin
      if (ociram_rd || ociram_wr) begin
        if (sq.size() == 0) begin
          chk("unexpected_strobe", {ociram_rd, ociram_wr, ociram_addr}, '0);
        end else begin
          s = sq.pop_front();
          chk("strobe",
              {ociram_rd, ociram_wr, ociram_addr, (ociram_wr ? ociram_wrdata : 32'h0), 32'(cyc)},
              {~s.is_wr, s.is_wr, s.addr, (s.is_wr ? s.data : 32'h0), 32'(s.due)});
        end
      end
      if (monitor_ready && !prev_ready) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 128'(dq.size()), 128'd1);
        end else begin
          d = dq.pop_front();
          chk("done", {MonDReg, monitor_error, 32'(cyc)}, {d.dreg, m_err, 32'(d.due)});
        end
      end
    end
    prev_ready = monitor_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic        a, b, n;
    logic [37:0] j;
    int          r;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      mem_model[i] = ram[i];
    end
    ram[16] = 32'hDEADBEEF;
    mem_model[16] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", monitor_ready, 1'b1);
    chk("rst_error", monitor_error, 1'b0);
    chk("rst_addr", ociram_addr, 8'h0);
    chk("rst_strobes", {ociram_rd, ociram_wr}, 2'b00);
    chk("rst_wrdata", ociram_wrdata, 32'h0);
    idle(1);

    issue(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h10));
    idle(3);

    issue(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b0, 8'h20));
    for (int i = 1; i <= 3; i++) begin
      issue(1'b0, 1'b1, 1'b0, mk_b(32'(i)));
      idle(1);
    end
    issue(1'b0, 1'b0, 1'b1, '0);
    idle(3);

    issue(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b0, 8'hFF));
    issue(1'b0, 1'b0, 1'b1, '0);
    idle(3);

    issue(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'hC8));
    idle(2);
    issue(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 8'h05));
    issue(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h05));
    idle(3);

    issue(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h30));
    issue(1'b0, 1'b1, 1'b0, mk_b(32'h12345678));
    idle(3);
    issue(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'h31));
    idle(3);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 4);
      b = (r >= 4 && r < 7);
      n = (r >= 7);
      if ($urandom_range(0, 9) == 0) begin
        b = 1'b1;
        n = 1'b1;
      end
      if (a) j = mk_a($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)));
      else   j = mk_b($urandom);
      issue(a, b, n, j);
      idle($urandom_range(0, 3));
    end
    idle(4);

    issue(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b1, 8'h10));
    reset = 1'b1;
    sq.delete();
    dq.delete();
    m_addr = '0; m_dreg = '0; m_err = 1'b0; ready_at = 0;
    #1;
    chk("midrst_ready", monitor_ready, 1'b1);
    chk("midrst_rd", ociram_rd, 1'b0);
    chk("midrst_mondreg", MonDReg, 32'h0);
    chk("midrst_addr", ociram_addr, 8'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    issue(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 8'h10));
    idle(4);

    chk("queues_drained", 128'(sq.size() + dq.size()), 128'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm_mcu_cpu_ocimem_monitor.md
# sm_mcu_cpu_ocimem_monitor

System-clock debug monitor that consumes the decoded JTAG debug actions (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`) and performs word reads/writes on the CPU's on-chip debug RAM. It sits directly downstream of the JTAG debug module's sysclk stage. It returns `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into that module's TCK-side capture path.

## Interface
Parameters:
- `AW`, 8, debug RAM word-address width (1..16).
- `DEPTH`, 256, number of implemented words. Must satisfy `DEPTH <= 2**AW`.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  debug data word from the JTAG sysclk stage.
- `take_action_ocimem_a`  in  1  one-cycle pulse: load address, optionally clear error, optionally read.
- `take_action_ocimem_b`  in  1  one-cycle pulse: write `jdo[34:3]` at the current address.
- `take_no_action_ocimem_a`  in  1  one-cycle pulse: increment address, then read.
- `ociram_addr`  out  AW  RAM word address (registered).
- `ociram_rd`  out  1  RAM read strobe (registered, 1 cycle).
- `ociram_wr`  out  1  RAM write strobe (registered, 1 cycle).
- `ociram_wrdata`  out  32  RAM write data (registered).
- `ociram_rddata`  in  32  RAM read data, valid the cycle after `ociram_rd`.
- `MonDReg`  out  32  last data read or written.
- `monitor_ready`  out  1  high when idle and the last access is complete.
- `monitor_error`  out  1  sticky access-error flag.

## Operation
- Address register `MonAReg[AW-1:0]` is internal.
- Command decode. Priority when pulses coincide: `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. Lower-priority pulses in the same cycle are dropped.
  - `take_action_ocimem_a`:
    - `MonAReg <= jdo[AW-1:0]`.
    - If `jdo[35]`, clear `monitor_error` (the clear is applied before any error raised by this command).
    - If `jdo[34]`, start a read at the new address.
  - `take_action_ocimem_b`:
    - `MonDReg <= jdo[34:3]`.
    - Write that value at `MonAReg`.
    - Then `MonAReg <= MonAReg+1`.
  - `take_no_action_ocimem_a`:
    - `MonAReg <= MonAReg+1`.
    - Then read at the incremented address.
- Address increment wraps modulo 2**AW. There is no saturation.
- Out-of-range access (address >= `DEPTH`):
  - No `ociram_rd`/`ociram_wr` strobe is issued.
  - `MonDReg` is unchanged for reads. For writes it still loads the `jdo` data.
  - `monitor_error` is set.
  - Completion timing is identical to a normal write.
- Busy rule: any command pulse arriving while `monitor_ready`=0 is ignored entirely (no address change) and sets `monitor_error`.
- FSM states:
  - IDLE: `ready`=1. A read command → RD_ISSUE. A write command or an out-of-range command → WR_DONE.
  - RD_ISSUE: `ociram_rd`=1, `ready`=0. → RD_CAP.
  - RD_CAP: capture `ociram_rddata` into `MonDReg`. → IDLE.
  - WR_DONE: `ociram_wr`=1 if in range, `ready`=0. → IDLE.
- `take_action_ocimem_a` with `jdo[34]`=0 changes only the address and error flag. It does not touch `monitor_ready`.

## Timing
- Reset values: `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `ociram_addr`=0, `ociram_rd`=0, `ociram_wr`=0, `ociram_wrdata`=0, `MonAReg`=0, state IDLE.
- Read (command sampled at edge E0):
  - After E0: `ready`=0, `ociram_rd`=1, `ociram_addr`=target.
  - After E1: `ociram_rd`=0. RAM data is valid.
  - After E2: `MonDReg`=data, `ready`=1.
  - Latency: 2 cycles to `ready`.
- Write (command sampled at E0):
  - After E0: `ready`=0, `ociram_wr`=1, `ociram_addr`/`ociram_wrdata` valid, `MonDReg` updated.
  - After E1: `ociram_wr`=0, `ready`=1, `MonAReg` incremented.
  - Latency: 1 cycle.
- `ociram_addr` holds its value between accesses.
- Strobes are single-cycle and never overlap.
- Reset asserted mid-access:
  - All outputs return to reset values immediately (asynchronous).
  - A pending read never updates `MonDReg`.
  - A pending write strobe is cut.
- Back-to-back commands: a pulse on the cycle `ready` returns high is accepted. A pulse on the last busy cycle is rejected with error.

## Test plan
- Reset, then `ocimem_a` with `jdo[7:0]`=0x10 and `jdo[34]`=1, RAM[0x10]=0xDEADBEEF → `ociram_rd` pulse with addr 0x10; after 2 cycles `MonDReg`=0xDEADBEEF, `ready`=1, `error`=0.
- Write sequence: three `ocimem_b` pulses with data 0x1, 0x2, 0x3 starting at 0x20 → writes at 0x20, 0x21, 0x22; final `MonDReg`=0x3, internal address 0x23.
- Wrap: address 0xFF, then `take_no_action_ocimem_a` (AW=8, DEPTH=256) → read issued at 0x00, no error.
- Out of range: DEPTH=200, load 0xC8 with read → no `ociram_rd`, `error`=1 after 1 cycle, `MonDReg` unchanged. Then `ocimem_a` with `jdo[35]`=1 → `error`=0.
- Busy collision: `ocimem_b` one cycle after a read command → ignored, `error`=1, read still completes with correct data.
- Reset mid-read: assert `reset` after E0 of a read → `ready`=1, `ociram_rd`=0, `MonDReg`=0 immediately; after release, a normal read succeeds.
